// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags (register status table).
// Dispatch returns source operands as ready values or producer tags; commit writes values and releases owning tags.
module reg_rename_file #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int AW    = $clog2(NREG)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        flush,
  input  logic                        dis_valid,
  input  logic [AW-1:0]               dis_rs1,
  input  logic [AW-1:0]               dis_rs2,
  input  logic [AW-1:0]               dis_rd,
  input  logic                        dis_rd_we,
  input  logic [TAG_W-1:0]            dis_tag,
  input  logic                        cmt_valid,
  input  logic [AW-1:0]               cmt_rd,
  input  logic [TAG_W-1:0]            cmt_tag,
  input  logic [XLEN-1:0]             cmt_val,
  output logic                        op_valid,
  output logic                        op_q1_busy,
  output logic [TAG_W-1:0]            op_q1,
  output logic [XLEN-1:0]             op_v1,
  output logic                        op_q2_busy,
  output logic [TAG_W-1:0]            op_q2,
  output logic [XLEN-1:0]             op_v2,
  output logic [$clog2(NREG+1)-1:0]   busy_count
);

  localparam int CW = $clog2(NREG + 1);

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } opnd_t;

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  opnd_t            opnd_q [2];
  opnd_t            opnd_d [2];
  logic             op_valid_q, op_valid_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    src [2];

  assign src[0] = dis_rs1;
  assign src[1] = dis_rs2;

  always_comb begin
    regs_d     = regs_q;
    tag_d      = tag_q;
    busy_d     = busy_q;
    opnd_d     = opnd_q;
    op_valid_d = 1'b0;

    if (flush) begin
      // Values survive a flush; only speculative ownership is discarded.
      busy_d = '0;
    end else begin
      op_valid_d = dis_valid;
      if (dis_valid) begin
        // Lookup uses pre-dispatch tag state so an instruction never waits on itself.
        for (int unsigned s = 0; s < 2; s++) begin
          if (busy_q[src[s]] && cmt_valid && (cmt_tag == tag_q[src[s]])) begin
            opnd_d[s] = '{busy: 1'b0, tag: '0, val: cmt_val};
          end else if (busy_q[src[s]]) begin
            opnd_d[s] = '{busy: 1'b1, tag: tag_q[src[s]], val: '0};
          end else begin
            opnd_d[s] = '{busy: 1'b0, tag: '0, val: regs_q[src[s]]};
          end
        end
      end

      if (cmt_valid && (cmt_rd != '0)) begin
        regs_d[cmt_rd] = cmt_val;
        if (busy_q[cmt_rd] && (tag_q[cmt_rd] == cmt_tag)) begin
          busy_d[cmt_rd] = 1'b0;
        end
      end

      // Applied after the commit clear so a same-register dispatch keeps ownership.
      if (dis_valid && dis_rd_we && (dis_rd != '0)) begin
        busy_d[dis_rd] = 1'b1;
        tag_d[dis_rd]  = dis_tag;
      end
    end

    count_d = CW'($countones(busy_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q     <= '{default: '0};
      tag_q      <= '{default: '0};
      busy_q     <= '0;
      opnd_q     <= '{default: '0};
      op_valid_q <= 1'b0;
      count_q    <= '0;
    end else if (rdy) begin
      regs_q     <= regs_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      opnd_q     <= opnd_d;
      op_valid_q <= op_valid_d;
      count_q    <= count_d;
    end
  end

  assign op_valid   = op_valid_q;
  assign op_q1_busy = opnd_q[0].busy;
  assign op_q1      = opnd_q[0].tag;
  assign op_v1      = opnd_q[0].val;
  assign op_q2_busy = opnd_q[1].busy;
  assign op_q2      = opnd_q[1].tag;
  assign op_v2      = opnd_q[1].val;
  assign busy_count = count_q;

endmodule

// File: tb/tb_reg_rename_file.sv
// Self-checking bench for reg_rename_file: directed scenarios plus randomized traffic
// compared against an array-based reference model of the rename table.
module tb_reg_rename_file;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int TAG_W = 4;
  localparam int AW    = 5;
  localparam int CW    = 6;
  localparam int OW    = 1 + 2 * (1 + TAG_W + XLEN) + CW;

  logic             clk = 1'b0;
  logic             rst, rdy, flush;
  logic             dis_valid, dis_rd_we, cmt_valid;
  logic [AW-1:0]    dis_rs1, dis_rs2, dis_rd, cmt_rd;
  logic [TAG_W-1:0] dis_tag, cmt_tag;
  logic [XLEN-1:0]  cmt_val;
  logic             op_valid, op_q1_busy, op_q2_busy;
  logic [TAG_W-1:0] op_q1, op_q2;
  logic [XLEN-1:0]  op_v1, op_v2;
  logic [CW-1:0]    busy_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0]  m_reg  [NREG];
  bit               m_busy [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];
  logic             e_valid, e_b1, e_b2;
  logic [TAG_W-1:0] e_q1, e_q2;
  logic [XLEN-1:0]  e_v1, e_v2;

  reg_rename_file #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .dis_valid(dis_valid), .dis_rs1(dis_rs1), .dis_rs2(dis_rs2), .dis_rd(dis_rd),
    .dis_rd_we(dis_rd_we), .dis_tag(dis_tag),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_val(cmt_val),
    .op_valid(op_valid), .op_q1_busy(op_q1_busy), .op_q1(op_q1), .op_v1(op_v1),
    .op_q2_busy(op_q2_busy), .op_q2(op_q2), .op_v2(op_v2), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] obs_vec();
    return {op_valid, op_q1_busy, op_q1, op_v1, op_q2_busy, op_q2, op_v2, busy_count};
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    int cnt = 0;
    for (int i = 0; i < NREG; i++) cnt += int'(m_busy[i]);
    return {e_valid, e_b1, e_q1, e_v1, e_b2, e_q2, e_v2, CW'(cnt)};
  endfunction

  task automatic lookup(input int s, output logic b, output logic [TAG_W-1:0] q,
                        output logic [XLEN-1:0] v);
    if (m_busy[s] && cmt_valid && cmt_tag == m_tag[s]) begin
      b = 1'b0; q = '0; v = cmt_val;
    end else if (m_busy[s]) begin
      b = 1'b1; q = m_tag[s]; v = '0;
    end else begin
      b = 1'b0; q = '0; v = (s == 0) ? '0 : m_reg[s];
    end
  endtask

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
      e_valid = 0; e_b1 = 0; e_q1 = '0; e_v1 = '0; e_b2 = 0; e_q2 = '0; e_v2 = '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        e_valid = 1'b0;
      end else begin
        e_valid = dis_valid;
        if (dis_valid) begin
          lookup(int'(dis_rs1), e_b1, e_q1, e_v1);
          lookup(int'(dis_rs2), e_b2, e_q2, e_v2);
        end
        if (cmt_valid && cmt_rd != 0) begin
          m_reg[cmt_rd] = cmt_val;
          if (m_busy[cmt_rd] && m_tag[cmt_rd] == cmt_tag) m_busy[cmt_rd] = 1'b0;
        end
        if (dis_valid && dis_rd_we && dis_rd != 0) begin
          m_busy[dis_rd] = 1'b1;
          m_tag[dis_rd]  = dis_tag;
        end
      end
    end
  endtask

  task automatic idle();
    rst = 0; rdy = 1; flush = 0; dis_valid = 0; dis_rd_we = 0; cmt_valid = 0;
    dis_rs1 = '0; dis_rs2 = '0; dis_rd = '0; dis_tag = '0;
    cmt_rd = '0; cmt_tag = '0; cmt_val = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic dis(input int rs1, input int rs2, input int rd, input bit we, input int tag);
    dis_valid = 1; dis_rs1 = AW'(rs1); dis_rs2 = AW'(rs2); dis_rd = AW'(rd);
    dis_rd_we = we; dis_tag = TAG_W'(tag);
  endtask

  task automatic cmt(input int rd, input int tag, input logic [XLEN-1:0] val);
    cmt_valid = 1; cmt_rd = AW'(rd); cmt_tag = TAG_W'(tag); cmt_val = val;
  endtask

  task automatic test_reset();
    rst = 1; dis(1, 2, 3, 1, 4); cmt(3, 4, 32'h55); flush = 1;
    tick();
    n_tests++;
    if (obs_vec() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", obs_vec());
    end
  endtask

  task automatic test_dispatch_basic();
    dis(3, 0, 5, 1, 2); tick();
    n_tests++;
    if ({op_valid, op_q1_busy, op_v1, op_q2_busy, op_v2, busy_count} !== {1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 6'd1}) begin
      n_fail++; $display("FAIL first_dispatch: got v=%b b1=%b v1=%h b2=%b v2=%h cnt=%0d want 1 0 0 0 0 1",
                         op_valid, op_q1_busy, op_v1, op_q2_busy, op_v2, busy_count);
    end
    dis(5, 0, 0, 0, 3); tick();
    n_tests++;
    if ({op_q1_busy, op_q1} !== {1'b1, 4'd2}) begin
      n_fail++; $display("FAIL src_busy_tag: got busy=%b q=%0d want busy=1 q=2", op_q1_busy, op_q1);
    end
    cmt(5, 2, 32'hDEADBEEF); tick();
    n_tests++;
    if (busy_count !== 6'd0) begin
      n_fail++; $display("FAIL commit_release_count: got %0d want 0", busy_count);
    end
    dis(5, 0, 0, 0, 0); tick();
    n_tests++;
    if ({op_q1_busy, op_v1} !== {1'b0, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL commit_value: got busy=%b v=%h want busy=0 v=deadbeef", op_q1_busy, op_v1);
    end
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL basic_model: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_bypass();
    dis(0, 0, 7, 1, 4); tick();
    dis(0, 7, 0, 0, 0); cmt(7, 4, 32'd99); tick();
    n_tests++;
    if ({op_q2_busy, op_q2, op_v2, busy_count} !== {1'b0, 4'd0, 32'd99, 6'd0}) begin
      n_fail++; $display("FAIL bypass: got busy=%b q=%0d v=%0d cnt=%0d want 0 0 99 0",
                         op_q2_busy, op_q2, op_v2, busy_count);
    end
  endtask

  task automatic test_stale_commit();
    dis(0, 0, 9, 1, 1); tick();
    dis(0, 0, 9, 1, 6); tick();
    n_tests++;
    if (busy_count !== 6'd1) begin
      n_fail++; $display("FAIL retag_count: got %0d want 1", busy_count);
    end
    cmt(9, 1, 32'd11); tick();
    dis(9, 0, 0, 0, 0); tick();
    n_tests++;
    if ({op_q1_busy, op_q1, busy_count} !== {1'b1, 4'd6, 6'd1}) begin
      n_fail++; $display("FAIL stale_commit: got busy=%b q=%0d cnt=%0d want 1 6 1", op_q1_busy, op_q1, busy_count);
    end
    flush = 1; tick();
    dis(9, 0, 0, 0, 0); tick();
    n_tests++;
    if ({op_q1_busy, op_v1} !== {1'b0, 32'd11}) begin
      n_fail++; $display("FAIL stale_value: got busy=%b v=%0d want 0 11", op_q1_busy, op_v1);
    end
  endtask

  task automatic test_flush();
    dis(0, 0, 1, 1, 1); tick();
    dis(0, 0, 2, 1, 2); tick();
    dis(0, 0, 3, 1, 3); tick();
    n_tests++;
    if (busy_count !== 6'd3) begin
      n_fail++; $display("FAIL flush_pre_count: got %0d want 3", busy_count);
    end
    flush = 1; dis(1, 2, 4, 1, 5); cmt(1, 1, 32'd77); tick();
    n_tests++;
    if ({op_valid, busy_count} !== {1'b0, 6'd0}) begin
      n_fail++; $display("FAIL flush_clear: got valid=%b cnt=%0d want 0 0", op_valid, busy_count);
    end
    dis(1, 2, 0, 0, 0); tick();
    n_tests++;
    if ({op_q1_busy, op_v1, op_q2_busy, op_v2} !== {1'b0, 32'd0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL flush_reads: got b1=%b v1=%0d b2=%b v2=%0d want 0 0 0 0",
                         op_q1_busy, op_v1, op_q2_busy, op_v2);
    end
    dis(4, 5, 0, 0, 0); tick();
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL flush_model: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_x0_rdy_rst();
    logic [OW-1:0] snap;
    dis(0, 0, 0, 1, 5); cmt(0, 0, 32'd5); tick();
    dis(0, 0, 0, 0, 0); tick();
    n_tests++;
    if ({op_valid, op_q1_busy, op_v1, op_q2_busy, op_v2, busy_count} !== {1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 6'd0}) begin
      n_fail++; $display("FAIL x0_read: got b1=%b v1=%0d b2=%b v2=%0d cnt=%0d want all 0",
                         op_q1_busy, op_v1, op_q2_busy, op_v2, busy_count);
    end
    dis(5, 9, 12, 1, 7); tick();
    snap = obs_vec();
    for (int k = 0; k < 3; k++) begin
      rdy = 0; dis(12, 1, 13, 1, 8); cmt(5, 0, 32'd1234); tick();
      n_tests++;
      if (obs_vec() !== snap) begin
        n_fail++; $display("FAIL rdy_hold[%0d]: got %h want %h", k, obs_vec(), snap);
      end
    end
    dis(12, 13, 0, 0, 0); tick();
    n_tests++;
    if ({op_q1_busy, op_q1, op_q2_busy, op_v2} !== {1'b1, 4'd7, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL rdy_ignored: got b1=%b q1=%0d b2=%b v2=%0d want 1 7 0 0",
                         op_q1_busy, op_q1, op_q2_busy, op_v2);
    end
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL rdy_model: got %h want %h", obs_vec(), exp_vec());
    end
    rst = 1; dis(12, 5, 14, 1, 9); cmt(5, 2, 32'd3); tick();
    n_tests++;
    if (obs_vec() !== '0) begin
      n_fail++; $display("FAIL mid_reset: got %h want 0", obs_vec());
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 79) == 0);
      rdy   = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) begin
        dis(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 1) == 1) begin
        r = int'($urandom_range(0, 7));
        cmt(r, ($urandom_range(0, 2) != 0) ? int'(m_tag[r]) : int'($urandom_range(0, 15)), $urandom);
      end
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_dispatch_basic();
    test_bypass();
    test_stale_commit();
    test_flush();
    test_x0_rdy_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
